// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: scans a shadow hex value across NUM_DIGITS anodes, one nibble per slot.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module hex_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_COUNT  = 50000,
    parameter int DATA_W     = 4 * NUM_DIGITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  LoadReq,
    input  logic [DATA_W-1:0]     Value,
    output logic                  LoadAck,
    output logic [3:0]            Nibble,
    output logic [NUM_DIGITS-1:0] DigitSel,
    output logic                  Blank
);

    localparam int CW = $clog2(DIV_COUNT);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_n;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_n;
    logic              ack_n;

    logic              slot_end;
    logic              frame_end;
    logic              accept;
    logic              blank_slot;
    logic [3:0]        nib [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib[g] = shadow[4*g +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero
    logic [NUM_DIGITS-1:0] upper_zero;

    assign upper_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);

    for (genvar g = 0; g < NUM_DIGITS - 1; g++) begin : g_uz
        assign upper_zero[g] = (nib[g] == 4'h0) && upper_zero[g+1];
    end

    assign blank_slot = (idx != '0) && upper_zero[idx];
`else
    assign blank_slot = 1'b0;
`endif

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            LoadAck <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shadow  <= shadow_n;
            LoadAck <= ack_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shadow_n = shadow;
        ack_n    = 1'b0;
        accept   = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                // a request still high during its own ack cycle is not taken twice
                accept = LoadReq && !LoadAck;
                if (Enable) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                accept = LoadReq && frame_end;
                if (!Enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else if (slot_end) begin
                    cnt_n = '0;
                    idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (accept) begin
            shadow_n = Value;
            ack_n    = 1'b1;
        end
    end

    always_comb begin
        Nibble   = 4'h0;
        DigitSel = '1;
        Blank    = 1'b1;
        if (state == SCAN) begin
            Nibble = nib[idx];
            if (!blank_slot) begin
                DigitSel[idx] = 1'b0;
                Blank         = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: scoreboard bench for hex_scan_ctrl against an elapsed-time display model.
// Honors LEADING_ZERO_BLANK_EN in the reference model as well.
module tb_hex_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int W     = 4 * N;
    localparam int FRAME = N * DIV;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         load_req;
    logic [W-1:0] value;
    logic         load_ack;
    logic [3:0]   nibble;
    logic [N-1:0] digit_sel;
    logic         blank;

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .NUM_DIGITS (N),
        .DIV_COUNT  (DIV)
    ) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Enable   (enable),
        .LoadReq  (load_req),
        .Value    (value),
        .LoadAck  (load_ack),
        .Nibble   (nibble),
        .DigitSel (digit_sel),
        .Blank    (blank)
    );

    typedef struct packed {
        logic         ack;
        logic [3:0]   nib;
        logic [N-1:0] sel;
        logic         blank;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    // model: scanning flag plus cycles elapsed since scan start
    bit           m_live   = 1'b0;
    bit           m_scan   = 1'b0;
    bit           m_ack    = 1'b0;
    int           m_t      = 0;
    logic [W-1:0] m_shadow = '0;

    function automatic exp_t model_out();
        exp_t         e;
        int           slot;
        logic [W-1:0] up;
        e.ack   = m_ack;
        e.nib   = 4'h0;
        e.sel   = '1;
        e.blank = 1'b1;
        if (m_scan) begin
            slot    = (m_t / DIV) % N;
            up      = m_shadow >> (4 * slot);
            e.nib   = up[3:0];
            e.blank = 1'b0;
            e.sel   = ~(N'(1) << slot);
`ifdef LEADING_ZERO_BLANK_EN
            if (slot != 0 && up == '0) begin
                e.sel   = '1;
                e.blank = 1'b1;
            end
`endif
        end
        return e;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            m_live   = 1'b1;
            m_scan   = 1'b0;
            m_t      = 0;
            m_shadow = '0;
            m_ack    = 1'b0;
        end else if (m_live) begin
            if (m_scan)
                acc = load_req && (m_t % FRAME == FRAME - 1);
            else
                acc = load_req && !m_ack;
            m_ack = acc;
            if (acc) m_shadow = value;
            if (!m_scan) begin
                m_scan = enable;
                m_t    = 0;
            end else if (!enable) begin
                m_scan = 1'b0;
                m_t    = 0;
            end else begin
                m_t = m_t + 1;
            end
        end
        if (m_live) exp_q.push_back(model_out());
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end else begin
            passed++;
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s @%0t: bound expired", name, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("load_ack", 32'(load_ack), 32'(e.ack));
            check("nibble", 32'(nibble), 32'(e.nib));
            check("digit_sel", 32'(digit_sel), 32'(e.sel));
            check("blank", 32'(blank), 32'(e.blank));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph);
        int k;
        for (k = 0; k < 4 * FRAME; k++) begin
            if (m_scan && (m_t % FRAME == ph)) break;
            tick();
        end
        if (k == 4 * FRAME) fail_now("wait_phase");
    endtask

    task automatic do_load(input logic [W-1:0] v, input int bound);
        int k;
        load_req = 1'b1;
        value    = v;
        for (k = 0; k < bound; k++) begin
            tick();
            if (load_ack) break;
        end
        if (k == bound) fail_now("load_ack_wait");
        load_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        load_req = 1'b0;
        value    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        do_load(16'h1A2F, 5);
        tick();
        tick();
        enable = 1'b1;
        repeat (40) tick();

        wait_phase(5);
        do_load(16'h0BEE, 2 * FRAME + 2);
        repeat (2 * FRAME) tick();

        wait_phase(9);
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        repeat (20) tick();

        wait_phase(FRAME - 1);
        enable   = 1'b0;
        load_req = 1'b1;
        value    = 16'h5A5A;
        tick();
        tick();
        load_req = 1'b0;
        enable   = 1'b1;
        repeat (FRAME + 4) tick();

        wait_phase(6);
        load_req = 1'b1;
        value    = 16'hFFFF;
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        load_req = 1'b0;
        repeat (FRAME + 4) tick();

        enable = 1'b0;
        tick();
        do_load(16'h0030, 5);
        enable = 1'b1;
        repeat (2 * FRAME + 2) tick();

        for (int c = 0; c < 4000; c++) begin
            if (load_req && load_ack)
                load_req = 1'b0;
            else if (load_req && $urandom_range(0, 63) == 0)
                load_req = 1'b0;
            else if (!load_req && $urandom_range(0, 15) == 0) begin
                load_req = 1'b1;
                value    = W'($urandom) >> (4 * $urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 99) < 3)
                enable = ~enable;
            else if (!enable && $urandom_range(0, 9) == 0)
                enable = 1'b1;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        reset    = 1'b0;
        load_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
